load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and access-legality helpers for the load/store unit.
// Pure declarations; no timing or flow-control behaviour lives here.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Unsigned loads have no store counterpart.
    function automatic logic f3_legal(input logic store, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] size_lo_mask(input logic [2:0] funct3);
        logic [1:0] m;
        case (funct3)
            F3_H, F3_HU: m = 2'b01;
            F3_W:        m = 2'b11;
            default:     m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and byte/half extraction plus sign/zero extension for loads.
// Purely combinational, zero latency; no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we_lanes,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        we_lanes    = 4'b0000;
        wdata_lanes = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                we_lanes    = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                we_lanes    = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
            end
            F3_W: begin
                we_lanes    = 4'b1111;
                wdata_lanes = wdata;
            end
            default: begin
                we_lanes    = 4'b0000;
                wdata_lanes = wdata;
            end
        endcase
    end

    // Halfword selection uses addr_lo[1] only; the caller guarantees addr_lo[0]==0 for H/HU.
    always_comb begin
        rbyte     = rdata[{addr_lo, 3'b000} +: 8];
        rhalf     = rdata[{addr_lo[1], 4'b0000} +: 16];
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_ext = {24'h0, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_ext = {16'h0, rhalf};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP; misalignment traps when LSU_MISALIGN_TRAP_EN is defined, else force-aligns.
// Latency: response valid two cycles after acceptance (one cycle for rejected requests).
// Backpressure: req_ready drops until the response is taken; response held stable while resp_ready is low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic [31:0] drdata
);

    lsu_state_t  state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;

    logic [1:0]  lo_mask;
    logic [31:0] addr_eff;
    logic        req_ok;

    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_we;
    logic [31:0] al_wd;
    logic [31:0] al_rd;

    always_comb begin
        lo_mask  = size_lo_mask(req_funct3);
        addr_eff = req_addr & ~{30'h0, lo_mask};
        req_ok   = f3_legal(req_store, req_funct3) && (req_addr < MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_addr[1:0] & lo_mask) != 2'b00) begin
            req_ok = 1'b0;
        end
`endif
    end

    // The aligner steers store lanes from the incoming request in IDLE and extracts load data from the latched request in ACCESS.
    always_comb begin
        if (state == IDLE) begin
            al_f3 = req_funct3;
            al_lo = addr_eff[1:0];
        end else begin
            al_f3 = f3_q;
            al_lo = lo_q;
        end
    end

    lsu_align u_align (
        .funct3      (al_f3),
        .addr_lo     (al_lo),
        .wdata       (req_wdata),
        .rdata       (drdata),
        .we_lanes    (al_we),
        .wdata_lanes (al_wd),
        .rdata_ext   (al_rd)
    );

    // we is a flop cleared by the async reset, so an aborted store never reaches the memory edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            we         <= 4'b0000;
            daddr      <= 32'h0;
            dwdata     <= 32'h0;
            st_q       <= 1'b0;
            f3_q       <= 3'b000;
            lo_q       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_q      <= req_store;
                        f3_q      <= req_funct3;
                        lo_q      <= addr_eff[1:0];
                        req_ready <= 1'b0;
                        if (req_ok) begin
                            state <= ACCESS;
                            daddr <= addr_eff;
                            if (req_store) begin
                                we     <= al_we;
                                dwdata <= al_wd;
                            end
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    we         <= 4'b0000;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= st_q ? 32'h0 : al_rd;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    we         <= 4'b0000;
                end
            endcase
        end
    end

endmodule
